// File: rtl/cam_pkg.sv
// Shared types and default geometry for the camera capture block.
package cam_pkg;

    localparam int unsigned DEF_H_PIXELS = 640;
    localparam int unsigned DEF_V_LINES  = 480;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BLANK,
        ST_WAIT_ACTIVE,
        ST_CAPTURE
    } cam_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous bit with rise/fall detection
// on the synchronized level.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/cam_capture.sv
// DVP-style camera capture: synchronizes the camera bus into clk_i, assembles
// byte pairs into RGB565 pixels and hands them out on a valid/ready port.
module cam_capture
    import cam_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned H_PIXELS    = DEF_H_PIXELS,
    parameter int unsigned V_LINES     = DEF_V_LINES
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        enable_i,
    input  logic                        cam_pclk_i,
    input  logic                        cam_vsync_i,
    input  logic                        cam_href_i,
    input  logic [7:0]                  cam_data_i,
    output logic [15:0]                 pixel_o,
    output logic                        pixel_valid_o,
    input  logic                        pixel_ready_i,
    output logic [$clog2(H_PIXELS)-1:0] col_o,
    output logic [$clog2(V_LINES)-1:0]  row_o,
    output logic                        frame_start_o,
    output logic                        line_end_o,
    output logic                        frame_end_o,
    output logic                        overflow_o,
    output logic                        size_err_o
);

    localparam int unsigned CW = $clog2(H_PIXELS);
    localparam int unsigned RW = $clog2(V_LINES);
    localparam logic [CW-1:0] COL_MAX = CW'(H_PIXELS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(V_LINES - 1);

    logic pc_level, pc_rise, pc_fall;
    logic hr_level, hr_rise, hr_fall;
    logic vs_level, vs_rise, vs_fall;
    logic unused_edges;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pclk (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(cam_pclk_i),
        .level_o(pc_level), .rise_o(pc_rise), .fall_o(pc_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_href (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(cam_href_i),
        .level_o(hr_level), .rise_o(hr_rise), .fall_o(hr_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_vsync (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(cam_vsync_i),
        .level_o(vs_level), .rise_o(vs_rise), .fall_o(vs_fall)
    );
    assign unused_edges = pc_level ^ pc_fall ^ hr_rise;

    // Same depth as the control bits so the byte is aligned with its pclk edge.
    logic [SYNC_STAGES-1:0][7:0] dsync_q, dsync_d;
    logic [7:0]                  data_s;
    assign dsync_d = {dsync_q[SYNC_STAGES-2:0], cam_data_i};
    assign data_s  = dsync_q[SYNC_STAGES-1];

    cam_state_e    state_q, state_d;
    logic [7:0]    hi_q, hi_d;
    logic          toggle_q, toggle_d;
    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic          col_full_q, col_full_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic          row_full_q, row_full_d;
    rgb565_t       pixel_q, pixel_d;
    logic          valid_q, valid_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          fs_q, fs_d, le_q, le_d, fe_q, fe_d;
    logic          ovf_q, ovf_d, serr_q, serr_d;

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        toggle_d   = toggle_q;
        col_cnt_d  = col_cnt_q;
        col_full_d = col_full_q;
        row_cnt_d  = row_cnt_q;
        row_full_d = row_full_q;
        pixel_d    = pixel_q;
        valid_d    = valid_q & ~pixel_ready_i;
        col_d      = col_q;
        row_d      = row_q;
        fs_d       = 1'b0;
        le_d       = 1'b0;
        fe_d       = 1'b0;
        ovf_d      = ovf_q;
        serr_d     = serr_q;

        unique case (state_q)
            ST_IDLE: if (enable_i) state_d = ST_WAIT_BLANK;
            ST_WAIT_BLANK: if (vs_level) state_d = ST_WAIT_ACTIVE;
            ST_WAIT_ACTIVE: begin
                if (vs_fall) begin
                    state_d    = ST_CAPTURE;
                    fs_d       = 1'b1;
                    toggle_d   = 1'b0;
                    col_cnt_d  = '0;
                    col_full_d = 1'b0;
                    row_cnt_d  = '0;
                    row_full_d = 1'b0;
                    ovf_d      = 1'b0;
                    serr_d     = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (vs_rise) begin
                    // Also the mid-line abort path: no line_end for a cut line.
                    state_d    = enable_i ? ST_WAIT_ACTIVE : ST_IDLE;
                    fe_d       = 1'b1;
                    toggle_d   = 1'b0;
                    col_cnt_d  = '0;
                    col_full_d = 1'b0;
                    row_cnt_d  = '0;
                    row_full_d = 1'b0;
                end else if (hr_fall) begin
                    le_d       = 1'b1;
                    toggle_d   = 1'b0;
                    col_cnt_d  = '0;
                    col_full_d = 1'b0;
                    if (row_cnt_q == ROW_MAX) row_full_d = 1'b1;
                    else                      row_cnt_d  = row_cnt_q + 1'b1;
                end else if (pc_rise && hr_level) begin
                    if (!toggle_q) begin
                        hi_d     = data_s;
                        toggle_d = 1'b1;
                    end else begin
                        toggle_d = 1'b0;
                        if (col_full_q || row_full_q) begin
                            serr_d = 1'b1;
                        end else begin
                            if (col_cnt_q == COL_MAX) col_full_d = 1'b1;
                            else                      col_cnt_d  = col_cnt_q + 1'b1;
                            if (valid_q && !pixel_ready_i) begin
                                ovf_d = 1'b1;
                            end else begin
                                pixel_d = rgb565_t'({hi_q, data_s});
                                col_d   = col_cnt_q;
                                row_d   = row_cnt_q;
                                valid_d = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            dsync_q    <= '0;
            hi_q       <= '0;
            toggle_q   <= 1'b0;
            col_cnt_q  <= '0;
            col_full_q <= 1'b0;
            row_cnt_q  <= '0;
            row_full_q <= 1'b0;
            pixel_q    <= '0;
            valid_q    <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            fs_q       <= 1'b0;
            le_q       <= 1'b0;
            fe_q       <= 1'b0;
            ovf_q      <= 1'b0;
            serr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dsync_q    <= dsync_d;
            hi_q       <= hi_d;
            toggle_q   <= toggle_d;
            col_cnt_q  <= col_cnt_d;
            col_full_q <= col_full_d;
            row_cnt_q  <= row_cnt_d;
            row_full_q <= row_full_d;
            pixel_q    <= pixel_d;
            valid_q    <= valid_d;
            col_q      <= col_d;
            row_q      <= row_d;
            fs_q       <= fs_d;
            le_q       <= le_d;
            fe_q       <= fe_d;
            ovf_q      <= ovf_d;
            serr_q     <= serr_d;
        end
    end

    assign pixel_o       = pixel_q;
    assign pixel_valid_o = valid_q;
    assign col_o         = col_q;
    assign row_o         = row_q;
    assign frame_start_o = fs_q;
    assign line_end_o    = le_q;
    assign frame_end_o   = fe_q;
    assign overflow_o    = ovf_q;
    assign size_err_o    = serr_q;

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture: drives whole camera frames and compares the pixel
// stream, pulses and error flags against a frame-level reference model.
module tb_cam_capture;

    localparam int unsigned H    = 4;
    localparam int unsigned V    = 3;
    localparam int unsigned SYNC = 3;
    localparam int unsigned CW   = $clog2(H);
    localparam int unsigned RW   = $clog2(V);

    logic          clk = 1'b0;
    logic          rst_n, enable, pclk, vsync, href, ready;
    logic [7:0]    data;
    logic [15:0]   pixel;
    logic          valid, fs, le, fe, ovf, serr;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    always #5 clk = ~clk;

    cam_capture #(.SYNC_STAGES(SYNC), .H_PIXELS(H), .V_LINES(V)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable),
        .cam_pclk_i(pclk), .cam_vsync_i(vsync), .cam_href_i(href), .cam_data_i(data),
        .pixel_o(pixel), .pixel_valid_o(valid), .pixel_ready_i(ready),
        .col_o(col), .row_o(row),
        .frame_start_o(fs), .line_end_o(le), .frame_end_o(fe),
        .overflow_o(ovf), .size_err_o(serr)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0]   px;
        logic [CW-1:0] c;
        logic [RW-1:0] r;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_last;
    bit          m_full, m_rprev, m_ovf, m_serr, m_en_prev, m_any;
    int unsigned n_fs = 0, n_le = 0, n_fe = 0;

    // Monitor: transfers commit at the next posedge; pulses counted per cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fs) n_fs++;
            if (le) n_le++;
            if (fe) n_fe++;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_pixel", {16'h0, pixel}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pixel", pixel, e.px);
                    check("col", col, e.c);
                    check("row", row, e.r);
                end
            end
        end
    end

    task automatic idle_pclk();
        pclk = 1'b0; #40;
        pclk = 1'b1; #40;
    endtask

    task automatic drive_byte(input logic [7:0] v, input bit set_rdy, input bit r);
        pclk = 1'b0; data = v; #40;
        pclk = 1'b1;
        if (set_rdy) ready = r;
        #40;
    endtask

    // One-slot output buffer seen at pixel granularity: the slot empties if
    // ready was high while the previous or the current pixel was in flight.
    task automatic pixel_event(input logic [15:0] px, input int unsigned pos,
                               input int unsigned line, input bit r);
        if (m_full && (m_rprev || r)) m_full = 1'b0;
        if (pos >= H || line >= V) begin
            m_serr = 1'b1;
        end else if (m_full) begin
            m_ovf = 1'b1;
        end else begin
            m_last = '{px, CW'(pos), RW'(line)};
            exp_q.push_back(m_last);
            m_full = 1'b1;
            m_any  = 1'b1;
        end
        m_rprev = r;
    endtask

    task automatic run_frame(input int unsigned nl, input int unsigned nb[4], input bit abort,
                             input int unsigned rdy_pct, input bit seq,
                             input bit en_start, input bit en_mid, input bit en_end);
        int unsigned s_fs, s_le, s_fe;
        bit          cap;
        logic [7:0]  v, hi, sv;
        bit          r;
        s_fs = n_fs; s_le = n_le; s_fe = n_fe;
        cap = m_en_prev || en_start;
        enable = en_start; vsync = 1'b1; href = 1'b0; ready = 1'b1;
        repeat (4) idle_pclk();
        if (cap) begin
            m_ovf = 1'b0; m_serr = 1'b0; m_full = 1'b0; m_rprev = 1'b1; m_any = 1'b0;
        end
        vsync = 1'b0;
        repeat (2) idle_pclk();
        sv = 8'h12;
        hi = 8'h00;
        for (int unsigned l = 0; l < nl; l++) begin
            if (l == 1) enable = en_mid;
            href = 1'b1;
            for (int unsigned b = 0; b < nb[l]; b++) begin
                if (seq) begin v = sv; sv = sv + 8'h22; end
                else v = 8'($urandom_range(255));
                if (b % 2 == 0) begin
                    hi = v;
                    r  = ($urandom_range(99) < rdy_pct);
                    drive_byte(v, (b + 1 < nb[l]), r);
                end else begin
                    if (cap) pixel_event({hi, v}, b / 2, l, r);
                    drive_byte(v, 1'b0, 1'b0);
                end
            end
            if (abort && l == nl - 1) begin
                enable = en_end; vsync = 1'b1;
                idle_pclk();
                href = 1'b0;
            end else begin
                href = 1'b0;
                repeat (2) idle_pclk();
            end
        end
        if (!abort) begin enable = en_end; vsync = 1'b1; end
        repeat (3) idle_pclk();
        ready = 1'b1;
        repeat (2) idle_pclk();
        check("frame_start_cnt", n_fs - s_fs, 32'(cap));
        check("frame_end_cnt", n_fe - s_fe, 32'(cap));
        check("line_end_cnt", n_le - s_le, cap ? nl - 32'(abort) : 0);
        check("pixels_pending", exp_q.size(), 0);
        check("overflow", ovf, m_ovf);
        check("size_err", serr, m_serr);
        if (cap && m_any) begin
            check("last_col", col, m_last.c);
            check("last_row", row, m_last.r);
        end
        exp_q.delete();
        m_en_prev = cap ? en_end : 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pixel"}, pixel, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_col"}, col, 0);
        check({tag, "_row"}, row, 0);
        check({tag, "_pulses"}, {fs, le, fe}, 0);
        check({tag, "_overflow"}, ovf, 0);
        check({tag, "_size_err"}, serr, 0);
    endtask

    int unsigned lb[4];

    initial begin
        rst_n = 1'b0; enable = 1'b0; pclk = 1'b0; vsync = 1'b0; href = 1'b0;
        data = 8'h00; ready = 1'b1;
        m_en_prev = 1'b0; m_full = 1'b0; m_rprev = 1'b1; m_ovf = 1'b0; m_serr = 1'b0; m_any = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check_reset_values("rst");
        rst_n = 1'b1;
        #20;

        lb = '{8, 8, 0, 0};  run_frame(2, lb, 0, 100, 1, 1, 1, 1);
        lb = '{4, 0, 0, 0};  run_frame(1, lb, 0, 0, 0, 1, 1, 1);
        lb = '{6, 4, 0, 0};  run_frame(2, lb, 0, 100, 0, 1, 1, 1);
        lb = '{5, 4, 0, 0};  run_frame(2, lb, 0, 100, 0, 1, 1, 1);
        lb = '{12, 0, 0, 0}; run_frame(1, lb, 0, 100, 0, 1, 1, 1);
        lb = '{4, 4, 4, 0};  run_frame(3, lb, 0, 100, 0, 1, 0, 0);
        lb = '{3, 0, 0, 0};  run_frame(1, lb, 1, 100, 0, 1, 0, 0);
        lb = '{4, 4, 0, 0};  run_frame(2, lb, 0, 100, 0, 0, 0, 0);
        lb = '{4, 4, 4, 4};  run_frame(4, lb, 0, 100, 0, 1, 1, 1);

        // Reset in the middle of a pixel while a pixel is held and overflow is set.
        begin
            int unsigned s_fs, s_le, s_fe;
            enable = 1'b1; vsync = 1'b1; ready = 1'b0;
            repeat (4) idle_pclk();
            vsync = 1'b0;
            repeat (2) idle_pclk();
            href = 1'b1;
            for (int unsigned b = 0; b < 5; b++) drive_byte(8'($urandom_range(1, 255)), 1'b0, 1'b0);
            check("pre_rst_valid", valid, 1);
            check("pre_rst_overflow", ovf, 1);
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            check_reset_values("mid_rst");
            #1;
            rst_n = 1'b1;
            ready = 1'b1;
            s_fs = n_fs; s_le = n_le; s_fe = n_fe;
            for (int unsigned b = 0; b < 3; b++) drive_byte(8'($urandom_range(255)), 1'b0, 1'b0);
            href = 1'b0;
            repeat (2) idle_pclk();
            vsync = 1'b1;
            repeat (3) idle_pclk();
            check("post_rst_fs", n_fs - s_fs, 0);
            check("post_rst_le", n_le - s_le, 0);
            check("post_rst_fe", n_fe - s_fe, 0);
            check("post_rst_valid", valid, 0);
            m_en_prev = 1'b1;
        end

        lb = '{8, 8, 0, 0}; run_frame(2, lb, 0, 100, 1, 1, 1, 1);

        for (int unsigned f = 0; f < 20; f++) begin
            int unsigned nl, pct;
            bit          ab;
            nl = $urandom_range(1, 4);
            for (int unsigned i = 0; i < 4; i++) lb[i] = $urandom_range(1, 11);
            ab = ($urandom_range(4) == 0);
            case ($urandom_range(2))
                0:       pct = 100;
                1:       pct = 50;
                default: pct = 20;
            endcase
            run_frame(nl, lb, ab, pct, 0, 1, 1, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for all camera inputs, legal range 2..4.
REQ-002 Parameter H_PIXELS, default 640: pixels per line accepted.
REQ-003 Parameter V_LINES, default 480: lines per frame accepted.
REQ-004 clk_i  in  1  system clock; the only clock in the block; rising edge only.
REQ-005 rst_n_i  in  1  reset; synchronous to clk_i, active-low.
REQ-006 enable_i  in  1  capture enable; sampled only at frame boundaries.
REQ-007 cam_pclk_i  in  1  camera pixel clock; asynchronous; treated as data, never used as a clock.
REQ-008 cam_vsync_i  in  1  camera vsync; high = vertical blanking.
REQ-009 cam_href_i  in  1  camera href; high = active line bytes.
REQ-010 cam_data_i  in  8  camera byte bus.
REQ-011 pixel_o  out  16  assembled RGB565 pixel; first byte of pair in [15:8].
REQ-012 pixel_valid_o  out  1  pixel_o holds an unconsumed pixel.
REQ-013 pixel_ready_i  in  1  downstream accept; transfer when valid and ready are both high.
REQ-014 col_o  out  $clog2(H_PIXELS)  column of pixel_o; row_o  out  $clog2(V_LINES)  row of pixel_o.
REQ-015 frame_start_o, line_end_o, frame_end_o  out  1 each  single-cycle pulses.
REQ-016 overflow_o, size_err_o  out  1 each  sticky error flags.

Function
REQ-017 Each camera input SHALL pass through SYNC_STAGES flops; all four SHALL use equal depth so they stay mutually aligned.
REQ-018 A pclk rising edge SHALL be detected when the synchronized pclk is 1 and its previous value is 0; href/vsync edges SHALL be detected the same way.
REQ-019 Precondition: clk_i SHALL be at least 4x cam_pclk_i; no behaviour is defined below that ratio.
REQ-020 FSM states: IDLE, WAIT_BLANK, WAIT_ACTIVE, CAPTURE.
REQ-021 IDLE -> WAIT_BLANK when enable_i=1; WAIT_BLANK -> WAIT_ACTIVE on synced vsync=1; WAIT_ACTIVE -> CAPTURE on vsync falling edge, pulsing frame_start_o that cycle.
REQ-022 CAPTURE -> on vsync rising edge: pulse frame_end_o; go to WAIT_ACTIVE if enable_i=1, else IDLE.
REQ-023 In CAPTURE, on each detected pclk edge with synced href=1, a byte SHALL be taken; a byte toggle selects high/low byte.
REQ-024 On the low-byte edge (cycle N), pixel_o, col_o, row_o and pixel_valid_o=1 SHALL be registered, visible in cycle N+1.
REQ-025 pixel_valid_o SHALL clear the cycle after a transfer unless a new pixel loads in the same cycle.
REQ-026 A new pixel arriving while pixel_valid_o=1 and pixel_ready_i=0 SHALL be dropped, pixel_o unchanged, overflow_o set.
REQ-027 On href falling edge in CAPTURE: pulse line_end_o, column counter to 0, byte toggle to 0 (odd trailing byte discarded), row counter +1.
REQ-028 Pixels with column >= H_PIXELS or rows >= V_LINES SHALL be dropped and set size_err_o; counters saturate, never wrap.
REQ-029 Vsync rising mid-line SHALL abort the line: no line_end_o, counters cleared, frame_end_o pulsed.
REQ-030 Row and column counters SHALL clear on frame_start_o.
REQ-031 overflow_o and size_err_o SHALL clear only on reset or on frame_start_o.
REQ-032 enable_i falling mid-frame SHALL NOT stop capture; effect occurs at frame end only.

Reset
REQ-033 With rst_n_i=0 at a clk_i edge: FSM=IDLE, all synchronizer and edge flops 0, counters 0, byte toggle 0.
REQ-034 Reset values: pixel_o=0, pixel_valid_o=0, col_o=0, row_o=0, all pulses 0, overflow_o=0, size_err_o=0.
REQ-035 Reset mid-pixel SHALL discard any held byte; no pixel emitted for it.

Structure
REQ-036 Package cam_pkg SHALL hold the FSM state enum, RGB565 pixel typedef and default resolution constants (640, 480).
REQ-037 Sub-module sync_edge (parameter SYNC_STAGES; outputs level, rise, fall) SHALL be instantiated for pclk, href and vsync; data uses a plain synchronizer vector.

Verification
REQ-038 Frame of 2 lines x 4 pixels, bytes 0x12,0x34,... , ready=1 -> pixels 0x1234,0x5678,... with col 0..3, row 0..1; 2 line_end_o, 1 frame_start_o, 1 frame_end_o.
REQ-039 ready=0 held across two pixels -> first pixel held stable, second dropped, overflow_o=1 until next frame_start_o.
REQ-040 Line with 5 bytes -> 2 pixels emitted, fifth byte discarded, next line col_o starts at 0.
REQ-041 H_PIXELS=4, line of 6 pixels -> 4 pixels emitted, size_err_o=1, col_o saturates at 3.
REQ-042 Vsync rises after 3 bytes of a line -> 1 pixel only, no line_end_o, frame_end_o pulsed; enable_i=0 -> FSM back to IDLE.
REQ-043 rst_n_i=0 for one cycle mid-pixel -> all outputs at reset values next cycle; capture resumes only after a full blank/active vsync sequence.
